// File: rtl/ff_pkg.sv
// Shared state encoding and per-layer geometry for the 2-5-5-3 forward-pass sequencer.
package ff_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      WRITE,
      DONE
   } state_t;

   localparam logic [1:0] LAYER_H1  = 2'd0;
   localparam logic [1:0] LAYER_H2  = 2'd1;
   localparam logic [1:0] LAYER_OUT = 2'd2;

   // Fan-in of a layer = node count of the layer feeding it.
   function automatic int unsigned layer_fan_in(input logic [1:0]  layer,
                                                input int unsigned n_in,
                                                input int unsigned n_h1,
                                                input int unsigned n_h2);
      int unsigned n;
      case (layer)
         LAYER_H1: n = n_in;
         LAYER_H2: n = n_h1;
         default:  n = n_h2;
      endcase
      return n;
   endfunction

   function automatic int unsigned layer_nodes(input logic [1:0]  layer,
                                               input int unsigned n_h1,
                                               input int unsigned n_h2,
                                               input int unsigned n_out);
      int unsigned n;
      case (layer)
         LAYER_H1: n = n_h1;
         LAYER_H2: n = n_h2;
         default:  n = n_out;
      endcase
      return n;
   endfunction

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ff_term_counter.sv
// Nested node/term counter; limits are latched on load so the walk of one layer
// is independent of what the sequencer computes for the next.
module ff_term_counter #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] term_lim_i,
   input  logic [CNT_W-1:0] node_lim_i,
   input  logic             term_inc_i,
   input  logic             node_inc_i,
   output logic [CNT_W-1:0] term_o,
   output logic [CNT_W-1:0] node_o,
   output logic             last_term_o,
   output logic             last_node_o
);

   logic [CNT_W-1:0] term_q, term_d;
   logic [CNT_W-1:0] node_q, node_d;
   logic [CNT_W-1:0] term_lim_q, term_lim_d;
   logic [CNT_W-1:0] node_lim_q, node_lim_d;

   assign last_term_o = (term_q == term_lim_q);
   assign last_node_o = (node_q == node_lim_q);
   assign term_o      = term_q;
   assign node_o      = node_q;

   always_comb begin
      term_d     = term_q;
      node_d     = node_q;
      term_lim_d = term_lim_q;
      node_lim_d = node_lim_q;
      if (load_i) begin
         term_d     = '0;
         node_d     = '0;
         term_lim_d = term_lim_i;
         node_lim_d = node_lim_i;
      end else begin
         // Term wraps on its own so the next node always starts at the bias.
         if (term_inc_i) begin
            term_d = last_term_o ? '0 : term_q + CNT_W'(1);
         end
         if (node_inc_i) begin
            node_d = node_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         term_q     <= '0;
         node_q     <= '0;
         term_lim_q <= '0;
         node_lim_q <= '0;
      end else begin
         term_q     <= term_d;
         node_q     <= node_d;
         term_lim_q <= term_lim_d;
         node_lim_q <= node_lim_d;
      end
   end

endmodule

// File: rtl/ff_layer_sequencer.sv
// Forward-pass sequencer: walks every layer/node/term of the Q-network through one
// shared MAC + leaky-ReLU, issuing RAM reads, MAC strobes and result writes.
//
//   state | meaning
//   IDLE  | waiting for i_valid
//   ISSUE | one weight (and data) read per cycle for the current node
//   WAIT  | all terms issued, waiting for the activated result
//   WRITE | result written to the layer's result RAM at the node index
//   DONE  | output layer complete, o_valid pulse
module ff_layer_sequencer
   import ff_pkg::*;
#(
   parameter int unsigned DATA_WIDTH                    = 32,
   parameter int unsigned ADDRESS_WIDTH                 = 5,
   parameter int unsigned NUMBER_OF_INPUT_NODE          = 2,
   parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = 5,
   parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = 5,
   parameter int unsigned NUMBER_OF_OUTPUT_NODE         = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_valid,
   output logic                     o_busy,
   output logic                     o_valid,
   output logic [1:0]               o_layer,
   output logic                     o_data_rd_en,
   output logic [ADDRESS_WIDTH-1:0] o_data_rd_addr,
   output logic                     o_weight_rd_en,
   output logic [ADDRESS_WIDTH-1:0] o_weight_rd_addr,
   output logic                     o_mac_first,
   output logic                     o_mac_valid,
   output logic                     o_mac_last,
   input  logic                     i_result_valid,
   output logic                     o_wr_en,
   output logic [ADDRESS_WIDTH-1:0] o_wr_addr
);

   localparam int unsigned N_IN  = NUMBER_OF_INPUT_NODE;
   localparam int unsigned N_H1  = NUMBER_OF_HIDDEN_NODE_LAYER_1;
   localparam int unsigned N_H2  = NUMBER_OF_HIDDEN_NODE_LAYER_2;
   localparam int unsigned N_OUT = NUMBER_OF_OUTPUT_NODE;

   localparam int unsigned MAX_WADDR =
      max3(N_H1 * (N_IN + 1), N_H2 * (N_H1 + 1), N_OUT * (N_H2 + 1)) - 1;

   // The datapath word never passes through here; only the geometry must fit.
   if (DATA_WIDTH < 1 || MAX_WADDR >= (32'd1 << ADDRESS_WIDTH)) begin : g_param_check
      $error("ff_layer_sequencer: ADDRESS_WIDTH too small or DATA_WIDTH invalid");
   end

   state_t                   state_q, state_d;
   logic [1:0]               layer_q, layer_d;
   logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
   logic                     mac_first_q, mac_valid_q, mac_last_q;

   logic                     cnt_load;
   logic                     term_inc;
   logic                     node_inc;
   logic [1:0]               lim_layer;
   logic [ADDRESS_WIDTH-1:0] term_lim;
   logic [ADDRESS_WIDTH-1:0] node_lim;
   logic [ADDRESS_WIDTH-1:0] term;
   logic [ADDRESS_WIDTH-1:0] node;
   logic                     last_term;
   logic                     last_node;

   assign term_lim = ADDRESS_WIDTH'(layer_fan_in(lim_layer, N_IN, N_H1, N_H2));
   assign node_lim = ADDRESS_WIDTH'(layer_nodes(lim_layer, N_H1, N_H2, N_OUT) - 1);

   ff_term_counter #(
      .CNT_W (ADDRESS_WIDTH)
   ) u_term_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (cnt_load),
      .term_lim_i  (term_lim),
      .node_lim_i  (node_lim),
      .term_inc_i  (term_inc),
      .node_inc_i  (node_inc),
      .term_o      (term),
      .node_o      (node),
      .last_term_o (last_term),
      .last_node_o (last_node)
   );

   always_comb begin
      state_d   = state_q;
      layer_d   = layer_q;
      waddr_d   = waddr_q;
      cnt_load  = 1'b0;
      term_inc  = 1'b0;
      node_inc  = 1'b0;
      lim_layer = LAYER_H1;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               state_d  = ISSUE;
               layer_d  = LAYER_H1;
               waddr_d  = '0;
               cnt_load = 1'b1;
            end
         end
         ISSUE: begin
            // Nodes of a layer are contiguous in its weight RAM, so a running
            // address equals node*(fan_in+1)+term without a multiplier.
            term_inc = 1'b1;
            waddr_d  = waddr_q + ADDRESS_WIDTH'(1);
            if (last_term) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (i_result_valid) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (!last_node) begin
               state_d  = ISSUE;
               node_inc = 1'b1;
            end else if (layer_q == LAYER_OUT) begin
               state_d = DONE;
            end else begin
               state_d   = ISSUE;
               layer_d   = layer_q + 2'd1;
               lim_layer = layer_q + 2'd1;
               waddr_d   = '0;
               cnt_load  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         layer_q     <= LAYER_H1;
         waddr_q     <= '0;
         mac_first_q <= 1'b0;
         mac_valid_q <= 1'b0;
         mac_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         layer_q     <= layer_d;
         waddr_q     <= waddr_d;
         // One register of delay lines the strobes up with the RAM read data.
         mac_first_q <= (state_q == ISSUE) && (term == '0);
         mac_valid_q <= (state_q == ISSUE);
         mac_last_q  <= (state_q == ISSUE) && last_term;
      end
   end

   assign o_busy           = (state_q != IDLE);
   assign o_valid          = (state_q == DONE);
   assign o_layer          = layer_q;
   assign o_weight_rd_en   = (state_q == ISSUE);
   assign o_weight_rd_addr = (state_q == ISSUE) ? waddr_q : '0;
   assign o_data_rd_en     = (state_q == ISSUE) && (term != '0);
   assign o_data_rd_addr   = o_data_rd_en ? term - ADDRESS_WIDTH'(1) : '0;
   assign o_mac_first      = mac_first_q;
   assign o_mac_valid      = mac_valid_q;
   assign o_mac_last       = mac_last_q;
   assign o_wr_en          = (state_q == WRITE);
   assign o_wr_addr        = (state_q == WRITE) ? node : '0;

endmodule

// File: doc/ff_layer_sequencer.md
# ff_layer_sequencer

Control FSM that runs one complete forward pass of the 2-5-5-3 Q-network through a single shared MAC + leaky-ReLU datapath. It sits between the start/done handshake of `feed_forward` and the per-layer data, weight and result RAMs. For each layer it walks every node and every input term, generates RAM read addresses and MAC control strobes, waits for each activated result, and writes that result into the layer's result RAM. It pulses `o_valid` once the output layer is complete.

## Interface
- `DATA_WIDTH`, 32, datapath word width; passed through only, no arithmetic here.
- `ADDRESS_WIDTH`, 5, width of all RAM addresses.
- `NUMBER_OF_INPUT_NODE`, 2, fan-in of hidden layer 1.
- `NUMBER_OF_HIDDEN_NODE_LAYER_1`, 5, node count of layer 0; fan-in of layer 1.
- `NUMBER_OF_HIDDEN_NODE_LAYER_2`, 5, node count of layer 1; fan-in of layer 2.
- `NUMBER_OF_OUTPUT_NODE`, 3, node count of layer 2.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `i_valid` input 1: start request, sampled only in IDLE.
- `o_busy` input→output 1: high whenever state ≠ IDLE.
- `o_valid` output 1: one-cycle done pulse.
- `o_layer` output 2: active layer. Encoding: 0 = hidden 1, 1 = hidden 2, 2 = output.
- `o_data_rd_en`, `o_data_rd_addr` output 1 / ADDRESS_WIDTH: read port of the previous layer's data RAM.
- `o_weight_rd_en`, `o_weight_rd_addr` output 1 / ADDRESS_WIDTH: read port of the active layer's weight RAM.
- `o_mac_first`, `o_mac_valid`, `o_mac_last` output 1 each: MAC strobes, aligned with RAM read data.
  - `o_mac_first` marks the bias term: the accumulator loads the weight times 1.0.
- `i_result_valid` input 1: activated node result is ready.
- `o_wr_en`, `o_wr_addr` output 1 / ADDRESS_WIDTH: write port of the active layer's result RAM. The address is the node index.

## Operation
- States and transitions:
  - IDLE → ISSUE on `i_valid`.
  - ISSUE → WAIT after the last term is issued.
  - WAIT → WRITE on `i_result_valid`.
  - WRITE → ISSUE for the next node, or ISSUE of the next layer, or DONE after the last node of layer 2.
  - DONE → IDLE unconditionally.
- Layer L has fan-in N_L and node count M_L. For node n, term t runs 0..N_L:
  - `o_weight_rd_addr` = n·(N_L+1)+t.
  - Term t=0 is the bias. The weight is read, and the data port is not enabled.
  - For t≥1: `o_data_rd_en`=1 and `o_data_rd_addr`=t−1.
- The weight address restarts at 0 for each layer, because each layer has its own weight RAM. The maximum address is 29 (layer 1: 5·6−1), which fits in 5 bits.
- The MAC strobes are the ISSUE-cycle flags delayed by one register, matching the 1-cycle RAM read latency:
  - `o_mac_first` for t=0.
  - `o_mac_last` for t=N_L.
  - `o_mac_valid` for every term.
- WRITE lasts one cycle: `o_wr_en`=1 and `o_wr_addr`=n.
- Ignored inputs:
  - `i_valid` in any state other than IDLE, including DONE.
  - `i_result_valid` outside WAIT.
- Reset: every output is 0, state is IDLE, and all counters are 0. Asserting reset mid-pass aborts the pass with no further writes and no `o_valid`.

## Timing
- `i_valid` is sampled at edge 0. The first ISSUE cycle, with weight address 0, is cycle 1.
- ISSUE lasts N_L+1 cycles per node: 3 cycles for layer 0 and 6 for layers 1 and 2.
- `o_mac_last` is high in the first WAIT cycle.
- If `i_result_valid` is high in WAIT cycle k, then:
  - `o_wr_en` is high in cycle k+1.
  - The next ISSUE starts in cycle k+2.
- `o_valid` is high in the DONE cycle, which immediately follows the final WRITE. `o_busy` is also high in that cycle.
- The earliest next accepted `i_valid` is in the cycle after DONE.
- `o_layer` changes in the first ISSUE cycle of the new layer. It holds its value through WRITE and DONE.

## Structure
- Package `ff_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, WRITE, DONE);
  - the layer encoding constants;
  - the per-layer fan-in and node-count functions, derived from the parameters.
- Sub-module `ff_term_counter`: nested node/term counter with a per-layer limit load. It outputs `last_term` and `last_node` flags.

## Test plan
- Layer 0 addressing: pulse `i_valid`. Check:
  - Weight addresses 0,1,2 in cycles 1–3.
  - Data addresses –,0,1.
  - `o_mac_first` in cycle 2 and `o_mac_last` in cycle 4.
- Full pass with the bench returning `i_result_valid` 2 cycles after each `o_mac_last`. Check:
  - Exactly 13 writes: addresses 0–4 for layer 0, 0–4 for layer 1, 0–2 for layer 2.
  - Exactly one `o_valid`.
  - The maximum weight address is 29.
- Result gap 10 cycles: the FSM holds WAIT with no RAM reads or strobes, then writes in the cycle after `i_result_valid`.
- Spurious inputs: `i_valid` mid-pass and in DONE, plus `i_result_valid` during ISSUE, are all ignored. The write count stays 13.
- Reset mid-pass: drop `rst_n` in layer 1, node 2. Check:
  - All outputs 0 immediately.
  - No `o_valid`.
  - A new `i_valid` restarts at layer 0, weight address 0.
- Back-to-back: `i_valid` held high continuously starts a second pass in the cycle after DONE.
